// File: rtl/rmw_counter_arbiter_if.sv
// Request/response bundle between two requesters and the shared counter block.
interface rmw_counter_arbiter_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic              req0_ready;
   logic              rsp0_valid;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic              req1_ready;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              init_busy;

   // Requester side: issues requests, sinks responses.
   modport master (
      output req0_valid, req0_addr, req1_valid, req1_addr,
      input  req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_data, init_busy
   );

   // Counter block side.
   modport slave (
      input  req0_valid, req0_addr, req1_valid, req1_addr,
      output req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_data, init_busy
   );
endinterface

// File: rtl/rmw_counter_arbiter.sv
// Two-requester read-modify-write counter memory: zeroes itself after reset,
// round-robin arbitrates, increments through a 2-stage pipeline and forwards
// the in-flight value on back-to-back hits to the same entry.
module rmw_counter_arbiter #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   rmw_counter_arbiter_if.slave    bus
);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;
   logic              ptr_q, ptr_d;

   logic              b_valid_q, b_valid_d;
   logic [ADDR_W-1:0] b_addr_q,  b_addr_d;
   logic              b_id_q,    b_id_d;
   logic [DATA_W-1:0] b_new_q,   b_new_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              active;
   logic              grant_vld;
   logic              grant_id;
   logic [ADDR_W-1:0] addr_g;
   logic [DATA_W-1:0] old_val;

   // Requests are only accepted in RUN and never in a reset cycle, so nothing
   // is granted that the reset would then silently throw away.
   assign active = (state_q == RUN) && !reset;

   // Round-robin arbitration: a lone request wins, a tie goes to the pointer.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (active) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ptr_q;
         end else if (bus.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
         end else if (bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign addr_g = grant_id ? bus.req1_addr : bus.req0_addr;

   // Stage B's value has not been written yet when the next request reads,
   // so a matching address takes the in-flight value instead of the array.
   assign old_val = (b_valid_q && (b_addr_q == addr_g)) ? b_new_q : mem_q[addr_g];

   // Next state: INIT sweeps every entry once, then RUN forever until reset.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (state_q == INIT) begin
         sweep_d = sweep_q + ADDR_W'(1);
         if (sweep_q == ADDR_W'(DEPTH - 1)) begin
            state_d = RUN;
         end
      end
   end

   // Stage A: capture the granted request and its incremented value.
   always_comb begin
      b_valid_d = grant_vld;
      b_addr_d  = b_addr_q;
      b_id_d    = b_id_q;
      b_new_d   = b_new_q;
      ptr_d     = ptr_q;
      if (grant_vld) begin
         b_addr_d = addr_g;
         b_id_d   = grant_id;
         b_new_d  = old_val + DATA_W'(1);
         ptr_d    = ~grant_id;
      end
   end

   // Control and pipeline registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= INIT;
         sweep_q   <= '0;
         ptr_q     <= 1'b0;
         b_valid_q <= 1'b0;
         b_addr_q  <= '0;
         b_id_q    <= 1'b0;
         b_new_q   <= '0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         ptr_q     <= ptr_d;
         b_valid_q <= b_valid_d;
         b_addr_q  <= b_addr_d;
         b_id_q    <= b_id_d;
         b_new_q   <= b_new_d;
      end
   end

   // Counter array write port: zeroing sweep in INIT, stage-B write in RUN.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch; it stays a plain RAM and the INIT
      // sweep clears it one entry per cycle instead.
      if (!reset) begin
         if (state_q == INIT) begin
            mem_q[sweep_q] <= '0;
         end else if (b_valid_q) begin
            mem_q[b_addr_q] <= b_new_q;
         end
      end
   end

   assign bus.req0_ready = grant_vld && !grant_id;
   assign bus.req1_ready = grant_vld &&  grant_id;
   assign bus.rsp0_valid = b_valid_q && !reset && !b_id_q;
   assign bus.rsp1_valid = b_valid_q && !reset &&  b_id_q;
   assign bus.rsp_data   = b_new_q;
   assign bus.init_busy  = (state_q == INIT);

endmodule

// File: tb/tb_rmw_counter_arbiter.sv
// Directed bench for rmw_counter_arbiter: stimulus pushes hand-computed
// responses into a scoreboard, a negedge monitor pops and compares them.
module tb_rmw_counter_arbiter;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;

   typedef struct {
      logic              id;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   exp_t sb_q [$];

   rmw_counter_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rmw_counter_arbiter #(.DEPTH(8), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive requests, check readys, and queue the
   // response expected next cycle for whichever requester should win.
   task automatic cycle(input logic v0, input logic [ADDR_W-1:0] a0,
                        input logic v1, input logic [ADDR_W-1:0] a1,
                        input logic er0, input logic er1,
                        input logic [DATA_W-1:0] ed, input bit push,
                        input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      reset          = 1'b0;
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      #1;
      check({tag, "_ready0"}, 32'(bus.req0_ready), 32'(er0));
      check({tag, "_ready1"}, 32'(bus.req1_ready), 32'(er1));
      if (push && (er0 || er1)) begin
         e.id   = er1;
         e.data = ed;
         sb_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset          = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      check("reset_rsp0_quiet", 32'(bus.rsp0_valid), 32'd0);
      check("reset_rsp1_quiet", 32'(bus.rsp1_valid), 32'd0);
   endtask

   // Response monitor.
   always @(negedge clk) begin
      exp_t e;
      if (bus.rsp0_valid || bus.rsp1_valid) begin
         check("rsp_onehot", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got rsp0=%0b rsp1=%0b data=%0h, expected no response",
                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
         end else begin
            e = sb_q.pop_front();
            check("rsp_id", 32'(bus.rsp1_valid), 32'(e.id));
            check("rsp_data", bus.rsp_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests          = 0;
      fails          = 0;
      reset          = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req0_addr  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_addr  = '0;

      // Init: 8 INIT cycles with req0 held, first grant in cycle 9.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1, 3'd0, 0, 3'd0, 0, 0, 0, 1, "init");
         check("init_busy", 32'(bus.init_busy), 32'd1);
         if (i == 0) begin
            check("init_rsp_data", bus.rsp_data, 32'd0);
            check("init_rsp0", 32'(bus.rsp0_valid), 32'd0);
            check("init_rsp1", 32'(bus.rsp1_valid), 32'd0);
         end
      end
      cycle(1, 3'd0, 0, 3'd0, 1, 0, 32'd1, 1, "init_first");
      cycle(0, 3'd0, 0, 3'd0, 0, 0, 0, 1, "idle");
      check("run_not_busy", 32'(bus.init_busy), 32'd0);

      // Back-to-back on addr 3 exercises forwarding, then a later hit.
      cycle(1, 3'd3, 0, 3'd0, 1, 0, 32'd1, 1, "b2b");
      cycle(1, 3'd3, 0, 3'd0, 1, 0, 32'd2, 1, "b2b");
      cycle(1, 3'd3, 0, 3'd0, 1, 0, 32'd3, 1, "b2b");
      cycle(1, 3'd3, 0, 3'd0, 1, 0, 32'd4, 1, "b2b");
      cycle(0, 3'd0, 0, 3'd0, 0, 0, 0, 1, "idle");
      cycle(1, 3'd3, 0, 3'd0, 1, 0, 32'd5, 1, "b2b_later");

      // Lone req1 hands the pointer back to requester 0.
      cycle(0, 3'd0, 1, 3'd7, 0, 1, 32'd1, 1, "solo1");

      // Round-robin with both requesters busy.
      cycle(1, 3'd1, 1, 3'd2, 1, 0, 32'd1, 1, "rr");
      cycle(1, 3'd1, 1, 3'd2, 0, 1, 32'd1, 1, "rr");
      cycle(1, 3'd1, 1, 3'd2, 1, 0, 32'd2, 1, "rr");
      cycle(1, 3'd1, 1, 3'd2, 0, 1, 32'd2, 1, "rr");
      cycle(1, 3'd1, 1, 3'd2, 1, 0, 32'd3, 1, "rr");
      cycle(1, 3'd1, 1, 3'd2, 0, 1, 32'd3, 1, "rr");

      // Same-address contention: second winner sees the forwarded value.
      cycle(1, 3'd5, 1, 3'd5, 1, 0, 32'd1, 1, "same");
      cycle(1, 3'd5, 1, 3'd5, 0, 1, 32'd2, 1, "same");
      cycle(0, 3'd0, 0, 3'd0, 0, 0, 0, 1, "idle");

      // Wrap: preload addr 0 to all-ones, next increment gives 0.
      dut.mem_q[0] = 32'hFFFF_FFFF;
      cycle(1, 3'd0, 0, 3'd0, 1, 0, 32'd0, 1, "wrap");
      cycle(0, 3'd0, 0, 3'd0, 0, 0, 0, 1, "idle");

      // Reset mid-op: accepted request is discarded, memory re-zeroed.
      cycle(0, 3'd0, 1, 3'd4, 0, 1, 32'd1, 0, "midop_accept");
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(0, 3'd0, 0, 3'd0, 0, 0, 0, 1, "reinit");
         check("reinit_busy", 32'(bus.init_busy), 32'd1);
      end
      cycle(0, 3'd0, 1, 3'd4, 0, 1, 32'd1, 1, "after_reset");
      cycle(0, 3'd0, 0, 3'd0, 0, 0, 0, 1, "idle");
      cycle(0, 3'd0, 0, 3'd0, 0, 0, 0, 1, "idle");

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
